// File: rtl/tow_pkg.sv
// Shared tug-of-war definitions: master controller states plus push-arbiter
// state encoding and priority-pointer constants.
package tow_pkg;

   typedef enum logic [2:0] {
      MstIdle   = 3'd0,
      MstPlay   = 3'd1,
      MstDark   = 3'd2,
      MstRandom = 3'd3,
      MstWin    = 3'd4
   } mst_state_e;

   typedef enum logic [1:0] {
      ArbIdle  = 2'd0,
      ArbArmed = 2'd1,
      ArbGrant = 2'd2,
      ArbLock  = 2'd3
   } arb_state_e;

   localparam logic PTR_LEFT  = 1'b0;
   localparam logic PTR_RIGHT = 1'b1;

   // Returns 1 when the left player wins this grant; ties go to the pointer.
   function automatic logic grant_left(input logic ptr, input logic press_l, input logic press_r);
      if (press_l && press_r) begin
         return (ptr == PTR_LEFT);
      end
      return press_l;
   endfunction

endpackage

// File: rtl/edge_rise.sv
// Rising-edge detector for one debounced button; the sample resets high so a
// button held through reset never looks like a fresh press.
module edge_rise (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic btn_i,
   output logic rise_o
);

   logic prev_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         prev_q <= 1'b1;
      end else begin
         prev_q <= btn_i;
      end
   end

   assign rise_o = btn_i & ~prev_q;

endmodule

// File: rtl/push_arbiter.sv
// Arbitrates player presses into one-cycle push pulses with a slow-tick lockout.
// Define FOUL_PENALTY_EN to also push toward the opponent of a fouling player.
module push_arbiter
   import tow_pkg::*;
#(
   parameter int unsigned LOCK_TICKS = 2,
   parameter int unsigned CNT_W      = 3
) (
   input  logic clk,
   input  logic rst_n,
   input  logic slowenable,
   input  logic play_en,
   input  logic dark,
   input  logic pbl,
   input  logic pbr,
   output logic push_l,
   output logic push_r,
   output logic foul_l,
   output logic foul_r,
   output logic busy
);

   arb_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ptr_q, ptr_d;
   logic             who_q, who_d;
   logic             foul_l_q, foul_r_q;
   logic             rise_l, rise_r;
   logic             press_l, press_r;
   logic             grant_l, grant_r;

   edge_rise u_edge_l (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .btn_i  (pbl),
      .rise_o (rise_l)
   );

   edge_rise u_edge_r (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .btn_i  (pbr),
      .rise_o (rise_r)
   );

   // Presses in the dark are fouls, never grant candidates.
   assign press_l = rise_l & ~dark;
   assign press_r = rise_r & ~dark;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      ptr_d   = ptr_q;
      who_d   = who_q;
      if (!play_en) begin
         state_d = ArbIdle;
         cnt_d   = '0;
      end else begin
         case (state_q)
            ArbIdle: begin
               state_d = ArbArmed;
            end
            ArbArmed: begin
               if (press_l || press_r) begin
                  state_d = ArbGrant;
                  who_d   = grant_left(ptr_q, press_l, press_r) ? PTR_LEFT : PTR_RIGHT;
                  ptr_d   = ~ptr_q;
               end
            end
            ArbGrant: begin
               state_d = ArbLock;
               cnt_d   = CNT_W'(LOCK_TICKS);
            end
            ArbLock: begin
               if (cnt_q == '0) begin
                  state_d = ArbArmed;
               end else if (slowenable) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end
            end
            default: begin
               state_d = ArbIdle;
               cnt_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ArbIdle;
         cnt_q    <= '0;
         ptr_q    <= PTR_LEFT;
         who_q    <= PTR_LEFT;
         foul_l_q <= 1'b0;
         foul_r_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         ptr_q    <= ptr_d;
         who_q    <= who_d;
         foul_l_q <= rise_l & dark;
         foul_r_q <= rise_r & dark;
      end
   end

   // Grant pulses depend only on the state, so an in-flight grant survives play_en dropping.
   assign grant_l = (state_q == ArbGrant) && (who_q == PTR_LEFT);
   assign grant_r = (state_q == ArbGrant) && (who_q == PTR_RIGHT);

`ifdef FOUL_PENALTY_EN
   logic pen_l, pen_r;

   // A double foul cancels out; a live grant always takes precedence.
   assign pen_l  = foul_r_q & ~foul_l_q & ~(grant_l | grant_r);
   assign pen_r  = foul_l_q & ~foul_r_q & ~(grant_l | grant_r);
   assign push_l = grant_l | pen_l;
   assign push_r = grant_r | pen_r;
`else
   assign push_l = grant_l;
   assign push_r = grant_r;
`endif

   assign foul_l = foul_l_q;
   assign foul_r = foul_r_q;
   assign busy   = (state_q == ArbGrant) || (state_q == ArbLock);

endmodule

// File: tb/tb_push_arbiter.sv
// Scoreboard bench for push_arbiter: directed presses queue expected pulses,
// a negedge monitor pops and compares every output pulse it sees.
module tb_push_arbiter;

   localparam int unsigned LockTicks = 2;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic slowenable = 1'b0;
   logic play_en = 1'b0;
   logic dark = 1'b0;
   logic pbl = 1'b0;
   logic pbr = 1'b0;
   logic push_l, push_r, foul_l, foul_r, busy;

   int cyc = 0;
   int checks = 0;
   int failures = 0;

   typedef struct {
      int         cyc;
      logic [3:0] vec;
   } exp_t;

   exp_t exp_q[$];

   push_arbiter #(
      .LOCK_TICKS (LockTicks),
      .CNT_W      (3)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .slowenable (slowenable),
      .play_en    (play_en),
      .dark       (dark),
      .pbl        (pbl),
      .pbr        (pbr),
      .push_l     (push_l),
      .push_r     (push_r),
      .foul_l     (foul_l),
      .foul_r     (foul_r),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Vector order: {push_l, push_r, foul_l, foul_r}; due one cycle after the drive.
   task automatic expect_out(input logic [3:0] v);
      exp_t e;
      e.cyc = cyc + 1;
      e.vec = v;
      exp_q.push_back(e);
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic slow();
      slowenable = 1'b1;
      tick(1);
      slowenable = 1'b0;
   endtask

   task automatic lockout();
      repeat (LockTicks) slow();
      tick(1);
   endtask

   task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [3:0] v;
      exp_t       e;
      v = {push_l, push_r, foul_l, foul_r};
      if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         checks++;
         failures++;
         $display("FAIL missed_pulse: got nothing in cycle %0d expected %b",
                  exp_q[0].cyc, exp_q[0].vec);
         void'(exp_q.pop_front());
      end
      if (v != 4'b0000) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_pulse: got %b in cycle %0d expected 0000", v, cyc);
         end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.vec !== v) begin
               failures++;
               $display("FAIL pulse: got %b in cycle %0d expected %b in cycle %0d",
                        v, cyc, e.vec, e.cyc);
            end
         end
      end
   end

   initial begin
      // Button held through reset and across play_en rising.
      rst_n = 1'b0;
      pbl   = 1'b1;
      tick(3);
      chk("reset_outputs", {push_l, push_r, foul_l, foul_r}, 4'b0000);
      chk("reset_busy", {3'b000, busy}, 4'b0000);
      rst_n = 1'b1;
      tick(2);
      play_en = 1'b1;
      tick(4);
      chk("held_no_busy", {3'b000, busy}, 4'b0000);
      pbl = 1'b0;
      tick(2);

      // Single press, then a discarded press during lockout.
      pbl = 1'b1;
      expect_out(4'b1000);
      tick(1);
      chk("grant_busy", {3'b000, busy}, 4'b0001);
      pbl = 1'b0;
      tick(1);
      chk("lock_busy", {3'b000, busy}, 4'b0001);
      pbl = 1'b1;
      tick(1);
      pbl = 1'b0;
      tick(1);
      lockout();
      chk("armed_not_busy", {3'b000, busy}, 4'b0000);

      // Fresh reset: ties go left first, then right.
      rst_n = 1'b0;
      tick(1);
      rst_n = 1'b1;
      tick(2);
      pbl = 1'b1;
      pbr = 1'b1;
      expect_out(4'b1000);
      tick(1);
      pbl = 1'b0;
      pbr = 1'b0;
      tick(1);
      lockout();
      pbl = 1'b1;
      pbr = 1'b1;
      expect_out(4'b0100);
      tick(1);
      pbl = 1'b0;
      pbr = 1'b0;
      tick(1);
      lockout();

      // Drop play_en in LOCK with one tick left, then re-arm and grant.
      pbl = 1'b1;
      expect_out(4'b1000);
      tick(1);
      pbl = 1'b0;
      tick(1);
      slow();
      play_en = 1'b0;
      tick(1);
      chk("abort_busy", {3'b000, busy}, 4'b0000);
      play_en = 1'b1;
      tick(2);
      pbr = 1'b1;
      expect_out(4'b0100);
      tick(1);
      pbr = 1'b0;
      tick(1);
      lockout();

      // Dark-phase fouls.
      play_en = 1'b0;
      dark    = 1'b1;
      tick(2);
      pbr = 1'b1;
`ifdef FOUL_PENALTY_EN
      expect_out(4'b1001);
`else
      expect_out(4'b0001);
`endif
      tick(1);
      pbr = 1'b0;
      tick(1);
      pbl = 1'b1;
`ifdef FOUL_PENALTY_EN
      expect_out(4'b0110);
`else
      expect_out(4'b0010);
`endif
      tick(1);
      pbl = 1'b0;
      tick(1);
      pbl = 1'b1;
      pbr = 1'b1;
      expect_out(4'b0011);
      tick(1);
      pbl = 1'b0;
      pbr = 1'b0;
      tick(2);
      dark = 1'b0;
      tick(3);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL queue_drained: got %0d pending expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
